// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Purpose  : UART receive path. The rx pin is synchronised and 8N1 characters
//            are framed LSB first, or 8 data + parity + stop when
//            UART_RX_PARITY_EN is defined. Each character is held in a
//            one-entry holding register until the CPU reads it.
// Ports    : clk        - system clock, posedge
//            reset      - synchronous, active-high
//            rx         - asynchronous serial input, idle high
//            readEnable - 1-cycle pulse, CPU consumed Data; clears flags
//            Data       - last received character
//            rxValid    - Data holds an unread character
//            busy       - frame in progress
//            frameErr   - sticky, stop bit sampled low
//            overrun    - sticky, character completed while Data unread
//            parityErr  - sticky, parity mismatch (0 without UART_RX_PARITY_EN)
// Config   : UART_RX_PARITY_EN - adds the parity bit and parity checking
// Revision : 1.0 - initial release
// ============================================================================
module uart_receiver #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   input  logic                 readEnable,
   output logic [DATA_BITS-1:0] Data,
   output logic                 rxValid,
   output logic                 busy,
   output logic                 frameErr,
   output logic                 overrun,
   output logic                 parityErr
);

   localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
   localparam int c_IDX_W = $clog2(DATA_BITS);
   localparam logic [c_CNT_W-1:0] c_HALF = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(DATA_BITS - 1);

   // Reject configurations the datapath cannot handle at elaboration time.
   if ((DATA_BITS != 8) || (CLKS_PER_BIT < 4) || ((CLKS_PER_BIT % 2) != 0) ||
       (PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_cfg_check
      $error("uart_receiver: unsupported parameter combination");
   end

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
      S_PARITY    = 3'd3,
`endif
      S_STOP      = 3'd4,
      S_WAIT_IDLE = 3'd5
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic                 r_rx_meta;
   logic                 r_rx_s;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [c_CNT_W-1:0]   w_cnt_next;
   logic [c_IDX_W-1:0]   r_idx;
   logic [c_IDX_W-1:0]   w_idx_next;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] w_shift_next;
   logic                 w_complete;
   logic                 w_frame_bad;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid;
   logic                 r_frame_err;
   logic                 r_overrun;
`ifdef UART_RX_PARITY_EN
   logic                 w_par_bad;
   logic                 r_parity_err;
`endif

   // Next-state and datapath. The bit-period counter only runs while a
   // frame is in progress and is cleared at every sample point, so each
   // start edge re-aligns the sampling phase.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt + 1'b1;
      w_idx_next   = r_idx;
      w_shift_next = r_shift;
      w_complete   = 1'b0;
      w_frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_bad    = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            w_cnt_next = '0;
            if (!r_rx_s) begin
               w_state_next = S_START;
            end
         end
         S_START: begin
            // Mid start bit: a high line here means the falling edge was a glitch.
            if (r_cnt == c_HALF) begin
               w_cnt_next   = '0;
               w_idx_next   = '0;
               w_state_next = r_rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (r_cnt == c_FULL) begin
               w_cnt_next   = '0;
               w_shift_next = {r_rx_s, r_shift[DATA_BITS-1:1]};
               if (r_idx == c_LAST) begin
`ifdef UART_RX_PARITY_EN
                  w_state_next = S_PARITY;
`else
                  w_state_next = S_STOP;
`endif
               end else begin
                  w_idx_next = r_idx + 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (r_cnt == c_FULL) begin
               w_cnt_next   = '0;
               w_state_next = S_STOP;
               // XOR over data plus parity bit is 0 for even, 1 for odd parity.
               w_par_bad    = (^{r_shift, r_rx_s}) != (PARITY_ODD != 0);
            end
         end
`endif
         S_STOP: begin
            if (r_cnt == c_FULL) begin
               w_cnt_next = '0;
               if (r_rx_s) begin
                  w_complete   = 1'b1;
                  w_state_next = S_IDLE;
               end else begin
                  w_frame_bad  = 1'b1;
                  w_state_next = S_WAIT_IDLE;
               end
            end
         end
         S_WAIT_IDLE: begin
            // Line held low (break): wait for it to return high before re-arming.
            w_cnt_next = '0;
            if (r_rx_s) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_cnt_next   = '0;
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_shift   <= '0;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_idx     <= w_idx_next;
         r_shift   <= w_shift_next;
      end
   end

   // Holding register and sticky flags. The read clear is written first so
   // that a flag set or a character load in the same cycle takes priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (readEnable) begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
         end
         if (w_complete) begin
            if (!r_valid || readEnable) begin
               r_data  <= r_shift;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end
         if (w_frame_bad) begin
            r_frame_err <= 1'b1;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         r_parity_err <= 1'b0;
      end else if (w_par_bad) begin
         r_parity_err <= 1'b1;
      end else if (readEnable) begin
         r_parity_err <= 1'b0;
      end
   end
   assign parityErr = r_parity_err;
`else
   assign parityErr = 1'b0;
`endif

   assign Data     = r_data;
   assign rxValid  = r_valid;
   assign frameErr = r_frame_err;
   assign overrun  = r_overrun;
   assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_receiver
// Purpose  : Self-checking bench for uart_receiver (CLKS_PER_BIT = 16).
//            Directed scenarios followed by random characters, compared
//            against a holding-register model of the receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

   localparam int c_CPB = 16;
   localparam int c_PO  = 0;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic       readEnable;
   logic [7:0] Data;
   logic       rxValid;
   logic       busy;
   logic       frameErr;
   logic       overrun;
   logic       parityErr;

   int checks = 0;
   int errors = 0;

   // Reference model: what the CPU should see in the holding register.
   logic [7:0] m_data  = 8'h00;
   logic       m_valid = 1'b0;
   logic       m_over  = 1'b0;
   logic       m_frame = 1'b0;
   logic       m_par   = 1'b0;

   always #5 clk = ~clk;

   uart_receiver #(
      .DATA_BITS   (8),
      .CLKS_PER_BIT(c_CPB),
      .PARITY_ODD  (c_PO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .readEnable(readEnable),
      .Data      (Data),
      .rxValid   (rxValid),
      .busy      (busy),
      .frameErr  (frameErr),
      .overrun   (overrun),
      .parityErr (parityErr)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One frame on the pin: start, 8 data bits LSB first, [parity], stop.
   // The line is left at the stop-bit level.
   task automatic send(input logic [7:0] b, input logic stop_bit, input logic par_flip);
      rx = 1'b0;
      idle(c_CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         idle(c_CPB);
      end
`ifdef UART_RX_PARITY_EN
      rx = (^b) ^ c_PO[0] ^ par_flip;
      idle(c_CPB);
`else
      if (par_flip) rx = 1'b1;
`endif
      rx = stop_bit;
      idle(c_CPB);
   endtask

   task automatic model_complete(input logic [7:0] b);
      if (!m_valid) begin
         m_data  = b;
         m_valid = 1'b1;
      end else begin
         m_over = 1'b1;
      end
   endtask

   task automatic read_pulse();
      readEnable = 1'b1;
      idle(1);
      readEnable = 1'b0;
      m_valid = 1'b0;
      m_over  = 1'b0;
      m_frame = 1'b0;
      m_par   = 1'b0;
   endtask

   task automatic check_model(input string tag);
      check({tag, "_data"},    Data,      m_data);
      check({tag, "_valid"},   rxValid,   m_valid);
      check({tag, "_overrun"}, overrun,   m_over);
      check({tag, "_frame"},   frameErr,  m_frame);
      check({tag, "_parity"},  parityErr, m_par);
   endtask

   initial begin
      int         lat;
      logic [7:0] b;

      reset      = 1'b1;
      rx         = 1'b1;
      readEnable = 1'b0;
      idle(3);
      check_model("reset");
      check("reset_busy", busy, 1'b0);
      reset = 1'b0;
      idle(5);

      // Single character with latency measured from the start edge.
      lat = 0;
      fork
         send(8'h48, 1'b1, 1'b0);
         begin
            while (!rxValid && lat < 300) begin
               @(negedge clk);
               lat++;
            end
         end
      join
      check("latency_window", (lat >= 150 && lat <= 160), 1'b1);
      model_complete(8'h48);
      check_model("char48");
      read_pulse();
      check_model("char48_read");

      // Two characters without a read: the second is dropped.
      send(8'hA5, 1'b1, 1'b0);
      model_complete(8'hA5);
      send(8'h3C, 1'b1, 1'b0);
      model_complete(8'h3C);
      check_model("overrun");
      read_pulse();
      check_model("overrun_read");

      // Short low glitch on the line.
      rx = 1'b0;
      idle(4);
      check("glitch_busy_hi", busy, 1'b1);
      idle(1);
      rx = 1'b1;
      idle(10);
      check("glitch_busy_lo", busy, 1'b0);
      check_model("glitch");

      // Stop bit low followed by a held-low line.
      send(8'h55, 1'b0, 1'b0);
      idle(24);
      m_frame = 1'b1;
      check_model("frame");
      check("frame_wait_busy", busy, 1'b1);
      rx = 1'b1;
      idle(4);
      check("frame_idle_busy", busy, 1'b0);
      check("frame_sticky", frameErr, 1'b1);
      read_pulse();
      check_model("frame_read");
      send(8'h01, 1'b1, 1'b0);
      model_complete(8'h01);
      check_model("after_frame");

      // Reset during data bit 4 of 8'hFF, with an unread character pending.
      read_pulse();
      send(8'hC3, 1'b1, 1'b0);
      model_complete(8'hC3);
      check_model("pre_reset");
      rx = 1'b0;
      idle(c_CPB);
      rx = 1'b1;
      idle(4 * c_CPB + c_CPB / 2);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      m_data  = 8'h00;
      m_valid = 1'b0;
      m_over  = 1'b0;
      m_frame = 1'b0;
      m_par   = 1'b0;
      check_model("mid_reset");
      check("mid_reset_busy", busy, 1'b0);
      idle(40);
      send(8'h0F, 1'b1, 1'b0);
      model_complete(8'h0F);
      check_model("after_reset");
      read_pulse();

`ifdef UART_RX_PARITY_EN
      send(8'h07, 1'b1, 1'b1);
      model_complete(8'h07);
      m_par = 1'b1;
      check_model("parity_bad");
      read_pulse();
      send(8'h07, 1'b1, 1'b0);
      model_complete(8'h07);
      check_model("parity_good");
      read_pulse();
`endif

      // Random characters, gaps and read decisions.
      for (int k = 0; k < 24; k++) begin
         b = 8'($urandom);
         send(b, 1'b1, 1'b0);
         model_complete(b);
         check_model("rand");
         check("rand_busy", busy, 1'b0);
         if ($urandom_range(0, 3) != 0) begin
            read_pulse();
            check("rand_read_valid", rxValid, 1'b0);
         end
         idle($urandom_range(0, 20));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
